// File: rtl/iomem_modmul.sv
// Memory-mapped modular multiplier R = (A * B) mod N on the iomem bus.
// Optional irq output and CTRL bit8 enable when IOMEM_MODMUL_IRQ_EN is defined.
module iomem_modmul #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        iomem_valid,
  input  logic [3:0]  iomem_wstrb,
  input  logic [31:0] iomem_addr,
  input  logic [31:0] iomem_wdata,
  output logic [31:0] iomem_rdata,
  output logic        iomem_ready
`ifdef IOMEM_MODMUL_IRQ_EN
  ,
  output logic        irq
`endif
);
  localparam int IW = $clog2(WIDTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CHECK = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             ready_q, ready_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, n_q, n_d;
  logic [WIDTH-1:0] r_q, r_d, result_q, result_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             done_q, done_d, err_q, err_d;
  logic             irq_en_q, irq_en_d;

  logic [2:0]       sel;
  logic             wr, start, busy;
  logic [31:0]      wmask, rmux;
  logic [WIDTH:0]   n_ext, r2, r3;

  logic unused_addr;
  assign unused_addr = ^{iomem_addr[31:5], iomem_addr[1:0]};

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] cur,
                                             input logic [31:0] wd,
                                             input logic [31:0] m);
    logic [31:0] t;
    t = (32'(cur) & ~m) | (wd & m);
    return t[WIDTH-1:0];
  endfunction

  assign sel   = iomem_addr[4:2];
  assign busy  = (state_q != S_IDLE);
  assign wmask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                  {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  // Writes commit during the ready cycle, while the master still holds the request.
  assign wr    = ready_q && iomem_valid && (|iomem_wstrb);
  assign start = wr && (sel == 3'd3) && iomem_wstrb[0] && iomem_wdata[0];

  always_comb begin
    ready_d  = iomem_valid && !ready_q;
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    n_d      = n_q;
    r_d      = r_q;
    result_d = result_q;
    idx_d    = idx_q;
    done_d   = done_q;
    err_d    = err_q;
    irq_en_d = irq_en_q;

    n_ext = {1'b0, n_q};
    r2    = {r_q, 1'b0};
    if (r2 >= n_ext) r2 = r2 - n_ext;
    r3 = b_q[idx_q] ? (r2 + {1'b0, a_q}) : r2;
    if (r3 >= n_ext) r3 = r3 - n_ext;

    if (wr && !busy) begin
      case (sel)
        3'd0: a_d = merge(a_q, iomem_wdata, wmask);
        3'd1: b_d = merge(b_q, iomem_wdata, wmask);
        3'd2: n_d = merge(n_q, iomem_wdata, wmask);
        default: ;
      endcase
    end
`ifdef IOMEM_MODMUL_IRQ_EN
    if (wr && (sel == 3'd3) && iomem_wstrb[1]) irq_en_d = iomem_wdata[8];
`endif

    case (state_q)
      S_IDLE: begin
        if (start) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if ((n_q == '0) || (a_q >= n_q) || (b_q >= n_q)) begin
          err_d    = 1'b1;
          done_d   = 1'b1;
          result_d = '0;
          state_d  = S_IDLE;
        end else begin
          r_d     = '0;
          idx_d   = IW'(WIDTH - 1);
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        r_d = r3[WIDTH-1:0];
        if (idx_q == '0) begin
          result_d = r3[WIDTH-1:0];
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end else begin
          idx_d = idx_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      ready_q  <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      n_q      <= '0;
      r_q      <= '0;
      result_q <= '0;
      idx_q    <= '0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      irq_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      a_q      <= a_d;
      b_q      <= b_d;
      n_q      <= n_d;
      r_q      <= r_d;
      result_q <= result_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
      err_q    <= err_d;
      irq_en_q <= irq_en_d;
    end
  end

  always_comb begin
    rmux = '0;
    case (sel)
      3'd0: rmux = 32'(a_q);
      3'd1: rmux = 32'(b_q);
      3'd2: rmux = 32'(n_q);
      3'd3: rmux = {23'd0, irq_en_q, 5'd0, err_q, done_q, busy};
      3'd4: rmux = 32'(result_q);
      default: rmux = '0;
    endcase
  end

  assign iomem_ready = ready_q;
  assign iomem_rdata = ready_q ? rmux : 32'd0;

`ifdef IOMEM_MODMUL_IRQ_EN
  assign irq = done_q & irq_en_q;
`endif

endmodule

// File: tb/tb_iomem_modmul.sv
// Directed bench for iomem_modmul: bus handshake, multiplies, errors, busy and reset abort.
module tb_iomem_modmul;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        iomem_valid = 1'b0;
  logic [3:0]  iomem_wstrb = 4'h0;
  logic [31:0] iomem_addr = '0;
  logic [31:0] iomem_wdata = '0;
  logic [31:0] iomem_rdata;
  logic        iomem_ready;
`ifdef IOMEM_MODMUL_IRQ_EN
  logic        irq;
`endif

  int tests = 0;
  int fails = 0;
  logic [31:0] rv;

  always #5 clk = ~clk;

  iomem_modmul #(.WIDTH(32)) dut (
    .clk(clk), .resetn(resetn),
    .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb),
    .iomem_addr(iomem_addr), .iomem_wdata(iomem_wdata),
    .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready)
`ifdef IOMEM_MODMUL_IRQ_EN
    , .irq(irq)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Request in cycle X, ready in X+1, returns just after the edge ending X+1.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wd,
                     input logic [3:0] st, output logic [31:0] rd);
    int n;
    @(negedge clk);
    iomem_valid = 1'b1;
    iomem_addr  = addr;
    iomem_wdata = wd;
    iomem_wstrb = st;
    n = 0;
    @(posedge clk); #1;
    while (!iomem_ready && n < 8) begin
      @(posedge clk); #1;
      n++;
    end
    if (!iomem_ready) chk("ack_timeout", {31'd0, iomem_ready}, 32'd1);
    rd = iomem_rdata;
    @(posedge clk); #1;
    chk("ready_1cyc", {31'd0, iomem_ready}, 32'd0);
    iomem_valid = 1'b0;
    iomem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [2:0] r, input logic [31:0] d);
    logic [31:0] dummy;
    bus({27'd0, r, 2'b00}, d, 4'hF, dummy);
  endtask

  task automatic rd(input logic [2:0] r, output logic [31:0] d);
    bus({27'd0, r, 2'b00}, 32'd0, 4'h0, d);
  endtask

  task automatic wait_done();
    logic [31:0] s;
    int n;
    n = 0;
    s = 0;
    while (!s[1] && n < 40) begin
      rd(3'd3, s);
      n++;
    end
    chk("done_timeout", {31'd0, s[1]}, 32'd1);
  endtask

  task automatic mul(input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] n, input logic [31:0] exp, input string tag);
    logic [31:0] r;
    wr(3'd0, a); wr(3'd1, b); wr(3'd2, n);
    wr(3'd3, 32'd1);
    wait_done();
    rd(3'd3, r); chk({tag, "_status"}, r & 32'h7, 32'h2);
    rd(3'd4, r); chk({tag, "_result"}, r, exp);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", {31'd0, iomem_ready}, 32'd0);
    chk("rst_rdata", iomem_rdata, 32'd0);
`ifdef IOMEM_MODMUL_IRQ_EN
    chk("rst_irq", {31'd0, irq}, 32'd0);
`endif
    @(negedge clk) resetn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      rd(i[2:0], rv);
      chk($sformatf("rst_reg%0d", i), rv, 32'd0);
    end

    // Basic multiply with exact latency: done first visible 34 cycles after the ack.
    wr(3'd0, 32'd7); wr(3'd1, 32'd9); wr(3'd2, 32'd13);
    rd(3'd0, rv); chk("readback_a", rv, 32'd7);
    wr(3'd3, 32'd1);
    repeat (30) @(posedge clk);
    rd(3'd3, rv); chk("lat_busy", rv, 32'h1);
    rd(3'd3, rv); chk("lat_done", rv, 32'h2);
    rd(3'd4, rv); chk("basic_result", rv, 32'd11);

    mul(32'hFFFF_FFFE, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h1, "wrap");
    mul(32'd100, 32'd200, 32'd257, 32'd211, "m257");
    mul(32'd0, 32'd5, 32'd13, 32'd0, "azero");

    // Errors flag two cycles after the ack and clear RESULT.
    wr(3'd0, 32'd0); wr(3'd1, 32'd0); wr(3'd2, 32'd0);
    wr(3'd3, 32'd1);
    rd(3'd3, rv); chk("err_n0_status", rv, 32'h6);
    rd(3'd4, rv); chk("err_n0_result", rv, 32'd0);
    wr(3'd0, 32'd13); wr(3'd1, 32'd1); wr(3'd2, 32'd13);
    wr(3'd3, 32'd1);
    rd(3'd3, rv); chk("err_a_ge_n", rv, 32'h6);
    wr(3'd0, 32'd1); wr(3'd1, 32'd20);
    wr(3'd3, 32'd1);
    rd(3'd3, rv); chk("err_b_ge_n", rv, 32'h6);

    // Busy protection: operand write and second start mid-run are dropped.
    wr(3'd0, 32'd7); wr(3'd1, 32'd9); wr(3'd2, 32'd13);
    wr(3'd3, 32'd1);
    rd(3'd3, rv); chk("busy_status", rv, 32'h1);
    wr(3'd0, 32'd5);
    wr(3'd3, 32'd1);
    rd(3'd0, rv); chk("busy_a_kept", rv, 32'd7);
    wait_done();
    rd(3'd3, rv); chk("busy_done", rv, 32'h2);
    rd(3'd4, rv); chk("busy_result", rv, 32'd11);

    // Byte strobes, read-only and unmapped registers.
    wr(3'd0, 32'hFFFF_FFFF);
    bus(32'h0, 32'h0000_1234, 4'b0010, rv);
    rd(3'd0, rv); chk("strobe_a", rv, 32'hFFFF_12FF);
    wr(3'd4, 32'hDEAD_BEEF);
    rd(3'd4, rv); chk("result_ro", rv, 32'd11);
    wr(3'd6, 32'h1234_5678);
    rd(3'd6, rv); chk("unmapped6", rv, 32'd0);
    rd(3'd5, rv); chk("unmapped5", rv, 32'd0);
    bus(32'h0A00_0008, 32'h0, 4'h0, rv); chk("addr_hi_ignored", rv, 32'd13);

    // Interrupt enable bit; done is still set from the previous multiply.
    wr(3'd3, 32'h100);
`ifdef IOMEM_MODMUL_IRQ_EN
    rd(3'd3, rv); chk("irqen_status", rv, 32'h102);
    chk("irq_level", {31'd0, irq}, 32'd1);
    wr(3'd0, 32'd3); wr(3'd1, 32'd4); wr(3'd2, 32'd13);
    wr(3'd3, 32'h101);
    chk("irq_clear_on_start", {31'd0, irq}, 32'd0);
    wait_done();
    chk("irq_on_done", {31'd0, irq}, 32'd1);
    rd(3'd4, rv); chk("irq_result", rv, 32'd12);
`else
    rd(3'd3, rv); chk("bit8_ignored", rv, 32'h2);
    mul(32'd3, 32'd4, 32'd13, 32'd12, "m12");
`endif

    // Reset abort around RUN cycle 10.
    wr(3'd0, 32'd100); wr(3'd1, 32'd200); wr(3'd2, 32'd257);
    wr(3'd3, 32'd1);
    repeat (9) @(posedge clk);
    @(negedge clk) resetn = 1'b0;
    @(negedge clk) resetn = 1'b1;
    #1;
    chk("abort_ready", {31'd0, iomem_ready}, 32'd0);
    rd(3'd3, rv); chk("abort_status", rv, 32'd0);
    rd(3'd4, rv); chk("abort_result", rv, 32'd0);
    rd(3'd0, rv); chk("abort_a", rv, 32'd0);
    mul(32'd7, 32'd9, 32'd13, 32'd11, "after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end
endmodule
